// File: rtl/rom_reader_if.sv
// rom_reader_if: output word stream of the ROM burst reader.
// master drives valid/data/last and samples ready; slave is the consumer.
interface rom_reader_if #(
  parameter int WORDSIZE = 16
) ();
  logic                out_valid;
  logic [WORDSIZE-1:0] out_data;
  logic                out_last;
  logic                out_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/rom_reader.sv
// rom_reader: burst fetch controller in front of a 1-cycle-latency ROM.
// Ports: clk, rst (sync, active-high); start/base_addr/len request a burst;
//   busy/done report status; rom_cs/rom_addr/rom_data talk to the ROM;
//   strm (rom_reader_if.master) streams words with valid/ready/last;
//   checksum is the running word sum when ROM_READER_CHECKSUM_EN is
//   defined, otherwise tied to 0.
module rom_reader #(
  parameter int WORDSIZE = 16,
  parameter int ADDRSIZE = 5,
  parameter int NUMADDR  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDRSIZE-1:0] base_addr,
  input  logic [ADDRSIZE:0]   len,
  output logic                busy,
  output logic                done,
  output logic                rom_cs,
  output logic [ADDRSIZE-1:0] rom_addr,
  input  logic [WORDSIZE-1:0] rom_data,
  rom_reader_if.master        strm,
  output logic [WORDSIZE-1:0] checksum
);

  localparam logic [ADDRSIZE:0]   L_MAX = (ADDRSIZE+1)'(NUMADDR);
  localparam logic [ADDRSIZE-1:0] L_TOP = ADDRSIZE'(NUMADDR-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDRSIZE:0]   r_len;
  logic [ADDRSIZE:0]   r_icnt;
  logic [ADDRSIZE:0]   r_dcnt;
  logic [ADDRSIZE-1:0] r_addr;
  logic                r_cs;
  logic                r_inflight;
  logic [WORDSIZE-1:0] r_mem [0:1];
  logic                r_rd;
  logic                r_wr;
  logic [1:0]          r_count;

  logic                w_valid;
  logic                w_pop;
  logic [2:0]          w_occ;
  logic                w_issue;
  logic                w_last_issue;
  logic                w_last_pop;
  logic [ADDRSIZE:0]   w_len;
  logic [ADDRSIZE-1:0] w_addr_nx;
  logic [WORDSIZE-1:0] w_head;

  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid & strm.out_ready;
  assign w_head  = r_mem[r_rd];

  // Slots already claimed once this cycle's pop is accounted for.
  assign w_occ = {1'b0, r_count}
               + {2'b0, r_inflight}
               - {2'b0, w_pop};

  assign w_issue      = (r_state == S_FETCH) && (w_occ < 3'd2);
  assign w_last_issue = w_issue && (r_icnt == r_len - 1'b1);
  assign w_last_pop   = w_pop && (r_dcnt == r_len - 1'b1);
  assign w_len        = (len > L_MAX) ? L_MAX : len;
  assign w_addr_nx    = (r_addr == L_TOP) ? '0 : r_addr + 1'b1;

  assign busy     = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);
  assign rom_cs   = r_cs;
  assign rom_addr = r_addr;

  assign strm.out_valid = w_valid;
  assign strm.out_data  = w_head;
  assign strm.out_last  = w_valid && (r_dcnt == r_len - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_icnt     <= '0;
      r_dcnt     <= '0;
      r_addr     <= '0;
      r_cs       <= 1'b0;
      r_inflight <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_count    <= '0;
    end else begin
      // rom_data belongs to the read issued last cycle.
      if (r_inflight) begin
        r_mem[r_wr] <= rom_data;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd   <= ~r_rd;
        r_dcnt <= r_dcnt + 1'b1;
      end
      r_count    <= r_count + {1'b0, r_inflight}
                            - {1'b0, w_pop};
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr <= w_addr_nx;
        r_icnt <= r_icnt + 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len  <= w_len;
            r_icnt <= '0;
            r_dcnt <= '0;
            r_addr <= base_addr;
            if (w_len == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_FETCH;
              r_cs    <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (w_last_issue) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Last read's data is captured at the end of the first
          // drain cycle, so chip select can drop here.
          r_cs <= 1'b0;
          if (w_last_pop) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  logic [WORDSIZE-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_sum <= '0;
    end else if (w_pop) begin
      r_sum <= r_sum + w_head;
    end
  end

  assign checksum = r_sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/rom_reader.md
Name: rom_reader

Overview:
Burst fetch controller that sits directly upstream of the 32x16 synchronous ROM. It drives the ROM's chip select and address, captures the registered read data, and streams words downstream over a valid/ready handshake. It absorbs the ROM's fixed 1-cycle read latency and downstream backpressure with a 2-entry output buffer. Typical use is loading coefficient or table data into a consumer at one word per cycle.

Parameters:
WORDSIZE, 16, ROM word width in bits
ADDRSIZE, 5, ROM address width in bits
NUMADDR, 32, number of ROM words; address arithmetic is modulo NUMADDR

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset
start  input  1  one-cycle request to begin a burst
base_addr  input  ADDRSIZE  first ROM address of burst, sampled with start
len  input  ADDRSIZE+1  number of words in burst, sampled with start
busy  output  1  high from accepted start until done pulse
done  output  1  one-cycle pulse when burst completes
rom_cs  output  1  ROM chip select
rom_addr  output  ADDRSIZE  ROM address
rom_data  input  WORDSIZE  ROM read data, valid the cycle after address presented while rom_cs high
out_valid  output  1  out_data holds a word
out_data  output  WORDSIZE  streamed word
out_last  output  1  qualifies final word of burst
out_ready  input  1  downstream accepts word when out_valid and out_ready both high
checksum  output  WORDSIZE  running sum, see Optional Feature

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on rising edge of clk).
- Reset values: busy=0, done=0, rom_cs=0, rom_addr=0, out_valid=0, out_data=0, out_last=0, checksum=0. Buffer count, in-flight flag, issue counter, and delivery counter all 0. FSM in IDLE.
- FSM: IDLE -> FETCH on start (len>0). FETCH -> DRAIN when len reads issued. DRAIN -> DONE when last word handshaken. DONE -> IDLE after one cycle (done=1, busy=0 in that cycle).
- start with len=0: no ROM access; FSM goes IDLE -> DONE; done pulses the cycle after start.
- len > NUMADDR is clamped to NUMADDR. start while busy is ignored.
- rom_cs is held high from FETCH entry until the last read's data is captured; it is low in IDLE and DONE.
- rom_addr for read i is (base_addr + i) mod NUMADDR, so wrap-around 31 -> 0 is required.
- Issue rule: a read is issued in a cycle when count + inflight - pop < 2, where pop = out_valid & out_ready. Data is captured at the end of the next cycle.
- Latency: start high in cycle 0 -> rom_addr=base in cycle 1 -> rom_data valid in cycle 2 -> out_valid=1 in cycle 3.
- With out_ready held high, throughput is 1 word/cycle and a burst of N takes N+3 cycles from start to last handshake.
- Buffer: 2-entry FIFO, in order. out_data/out_valid are stable while out_valid & !out_ready. It never overflows: the issue rule guarantees a free slot for every in-flight word.
- out_last=1 exactly with word len-1. done pulses the cycle after that word's handshake.
- Simultaneous push and pop on the buffer: count unchanged, ordering preserved.
- rst mid-burst: returns to reset values on the next edge. In-flight ROM data is discarded and no done pulse is generated.

Optional Feature:
ROM_READER_CHECKSUM_EN
- Defined: checksum clears to 0 on an accepted start. Each handshaken word is added mod 2^WORDSIZE. The value holds after done until the next start.
- Undefined: checksum is tied to 0 and no adder is built.

Test Plan:
Bench ROM model is preloaded with memory[i]=16'hA000+i.
- start, base=4, len=3, out_ready=1 -> out_data A004, A005, A006 in cycles 3, 4, 5; out_last in cycle 5; done in cycle 6; rom_cs low in cycle 6.
- start, base=30, len=4 -> words A01E, A01F, A000, A001 (address wrap); out_last on A001.
- base=0, len=8, out_ready toggling 1,0,0,1,... -> all 8 words A000..A007 in order with none dropped or duplicated; out_data stable while stalled; never more than 2 reads outstanding.
- len=0 -> rom_cs stays 0, no out_valid, done pulses cycle 1. Then len=40 -> exactly 32 words with wrap; out_last on the 32nd.
- rst asserted in cycle 4 of a len=10 burst -> next cycle all outputs at reset values; no done pulse. A new start then behaves normally.
- ROM_READER_CHECKSUM_EN defined, base=0, len=4 -> checksum=16'h8006 after done (4*A000+0+1+2+3 mod 2^16). Undefined -> checksum=0.
